// File: rtl/reversi_pkg.sv
// Shared definitions for the Reversi game controller.
//   state_t      : turn sequencer FSM states
//   BLACK/WHITE  : player indices of the two-colour game
//   next_player  : round-robin successor with wrap to player 0
package reversi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_PLAY,
    ST_ADVANCE,
    ST_OVER
  } state_t;

  localparam int BLACK = 0;
  localparam int WHITE = 1;

  function automatic int next_player(input int cur, input int num_players);
    return (cur == num_players - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-move timeout down-counter.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset, clears the count
//   load_i   : load TIMEOUT_CYCLES (takes priority over counting)
//   en_i     : count down one step per cycle while high
//   expire_o : high during the last enabled cycle of the budget
module turn_timer #(
  parameter  int TIMEOUT_CYCLES = 1,
  localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(TIMEOUT_CYCLES);
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Expiry is flagged while the final cycle is still in progress so that a
  // move_done arriving in that same cycle can override it.
  assign expire_o = en_i && (count_q == CW'(1));

endmodule

// File: rtl/turn_sequencer.sv
// Round-robin turn sequencer for N-player Reversi.
//   clk            : clock, rising edge
//   resetn         : asynchronous reset, active-high despite its name
//   start          : begin/restart a game (highest priority)
//   move_done      : current player's move fully applied
//   check_ack      : legality checker response valid
//   has_legal      : current player has a legal move (with check_ack)
//   check_req      : legality check requested for current_player
//   current_player : player whose turn it is
//   turn_active    : waiting for current_player's move
//   pass_count     : consecutive passes so far
//   timed_out      : one-cycle pulse when a move times out
//   turn_number    : completed moves since start, saturating
//   game_over      : sticky end-of-game flag
module turn_sequencer
  import reversi_pkg::*;
#(
  parameter  int NUM_PLAYERS    = 2,
  parameter  int START_PLAYER   = BLACK,
  parameter  int TIMEOUT_CYCLES = 0,
  parameter  int TURN_W         = 8,
  localparam int PW             = $clog2(NUM_PLAYERS),
  localparam int PCW            = $clog2(NUM_PLAYERS + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              move_done,
  input  logic              check_ack,
  input  logic              has_legal,
  output logic              check_req,
  output logic [PW-1:0]     current_player,
  output logic              turn_active,
  output logic [PCW-1:0]    pass_count,
  output logic              timed_out,
  output logic [TURN_W-1:0] turn_number,
  output logic              game_over
);

  state_t             state_q, state_d;
  logic [PW-1:0]      player_q, player_d;
  logic [PCW-1:0]     pass_q, pass_d, pass_inc;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               timed_out_q, timed_out_d;
  logic               game_over_q, game_over_d;
  logic               timer_load, timer_expire;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i    (clk),
        .rst_i    (resetn),
        .load_i   (timer_load),
        .en_i     (state_q == ST_PLAY),
        .expire_o (timer_expire)
      );
    end else begin : g_no_timer
      logic unused_timer_load;
      assign unused_timer_load = timer_load;
      assign timer_expire      = 1'b0;
    end
  endgenerate

  assign pass_inc = pass_q + PCW'(1);

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    pass_d      = pass_q;
    turn_d      = turn_q;
    timed_out_d = 1'b0;
    game_over_d = game_over_q;
    timer_load  = 1'b0;

    if (start) begin
      state_d     = ST_QUERY;
      player_d    = PW'(START_PLAYER);
      pass_d      = '0;
      turn_d      = '0;
      game_over_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_QUERY: begin
          if (check_ack) begin
            if (has_legal) begin
              state_d    = ST_PLAY;
              pass_d     = '0;
              timer_load = 1'b1;
            end else begin
              pass_d = pass_inc;
              if (pass_inc == PCW'(NUM_PLAYERS)) begin
                state_d     = ST_OVER;
                game_over_d = 1'b1;
              end else begin
                state_d = ST_ADVANCE;
              end
            end
          end
        end
        ST_PLAY: begin
          // A move completing in the expiry cycle beats the timeout.
          if (move_done) begin
            state_d = ST_ADVANCE;
            turn_d  = (turn_q == '1) ? turn_q : turn_q + TURN_W'(1);
          end else if (timer_expire) begin
            timed_out_d = 1'b1;
            pass_d      = pass_inc;
            if (pass_inc == PCW'(NUM_PLAYERS)) begin
              state_d     = ST_OVER;
              game_over_d = 1'b1;
            end else begin
              state_d = ST_ADVANCE;
            end
          end
        end
        ST_ADVANCE: begin
          player_d = PW'(next_player(int'(player_q), NUM_PLAYERS));
          state_d  = ST_QUERY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      player_q    <= PW'(START_PLAYER);
      pass_q      <= '0;
      turn_q      <= '0;
      timed_out_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      pass_q      <= pass_d;
      turn_q      <= turn_d;
      timed_out_q <= timed_out_d;
      game_over_q <= game_over_d;
    end
  end

  assign check_req      = (state_q == ST_QUERY);
  assign turn_active    = (state_q == ST_PLAY);
  assign current_player = player_q;
  assign pass_count     = pass_q;
  assign turn_number    = turn_q;
  assign timed_out      = timed_out_q;
  assign game_over      = game_over_q;

endmodule
